// File: rtl/mem_arbiter_if.sv
// Bundle of requester (IFU/LSU) and memory-port signals for mem_arbiter.
// master = the arbiter itself, slave = the surrounding core/memory environment.
interface mem_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic        ifu_resp_err;
    logic [31:0] ifu_rdata;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic        lsu_resp_err;
    logic [31:0] lsu_rdata;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    logic        busy;

    modport master (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output busy
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU, with a response watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise LSU wins ties.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    owner_t      owner;
    logic [7:0]  wd;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [7:0]  wmask_q;

    logic        grant_ifu, grant_lsu;
    logic        lsu_pref;
    logic        wd_fire;
    logic        resp_fire;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_grant;
    assign lsu_pref = (last_grant == OWN_IFU);
`else
    assign lsu_pref = 1'b1;
`endif

    // A real response in the final watchdog cycle takes precedence over the error.
    assign wd_fire = (state == WAIT) && !bus.mem_resp_valid && (wd == WD_LAST);

    always_comb begin
        state_n            = state;
        grant_ifu          = 1'b0;
        grant_lsu          = 1'b0;
        resp_fire          = 1'b0;
        bus.ifu_req_ready  = 1'b0;
        bus.lsu_req_ready  = 1'b0;
        bus.ifu_resp_valid = 1'b0;
        bus.ifu_resp_err   = 1'b0;
        bus.ifu_rdata      = '0;
        bus.lsu_resp_valid = 1'b0;
        bus.lsu_resp_err   = 1'b0;
        bus.lsu_rdata      = '0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_addr       = addr_q;
        bus.mem_wen        = wen_q;
        bus.mem_wdata      = wdata_q;
        bus.mem_wmask      = wmask_q;
        bus.busy           = (state != IDLE);

        case (state)
            IDLE: begin
                if (bus.lsu_req_valid && (!bus.ifu_req_valid || lsu_pref))
                    grant_lsu = 1'b1;
                else if (bus.ifu_req_valid)
                    grant_ifu = 1'b1;
                if (grant_lsu || grant_ifu)
                    state_n = REQ;
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready)
                    state_n = WAIT;
            end
            WAIT: begin
                if (bus.mem_resp_valid || wd_fire) begin
                    resp_fire = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Ready is held low while reset is asserted so every output reads 0.
        bus.ifu_req_ready = grant_ifu && !rst;
        bus.lsu_req_ready = grant_lsu && !rst;

        if (resp_fire) begin
            if (owner == OWN_LSU) begin
                bus.lsu_resp_valid = 1'b1;
                bus.lsu_resp_err   = wd_fire;
                bus.lsu_rdata      = wd_fire ? ERR_DATA : bus.mem_rdata;
            end else begin
                bus.ifu_resp_valid = 1'b1;
                bus.ifu_resp_err   = wd_fire;
                bus.ifu_rdata      = wd_fire ? ERR_DATA : bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= OWN_IFU;
            wd      <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= OWN_IFU;
`endif
        end else begin
            state <= state_n;

            if (grant_lsu) begin
                addr_q  <= bus.lsu_addr;
                wen_q   <= bus.lsu_wen;
                wdata_q <= bus.lsu_wdata;
                wmask_q <= bus.lsu_wmask;
                owner   <= OWN_LSU;
            end else if (grant_ifu) begin
                addr_q  <= bus.ifu_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
                owner   <= OWN_IFU;
            end

`ifdef ARB_ROUND_ROBIN_EN
            if (grant_lsu)
                last_grant <= OWN_LSU;
            else if (grant_ifu)
                last_grant <= OWN_IFU;
`endif

            if (state == REQ)
                wd <= '0;
            else if ((state == WAIT) && !resp_fire)
                wd <= wd + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_lsu = 1'b0;
`endif

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic lsu_wins_tie();
`ifdef ARB_ROUND_ROBIN_EN
        return !last_lsu;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet_resp(input string tag);
        check({tag, "_ifu_rv"}, 32'(bus.ifu_resp_valid), 32'd0);
        check({tag, "_lsu_rv"}, 32'(bus.lsu_resp_valid), 32'd0);
        check({tag, "_ifu_rd"}, bus.ifu_rdata, 32'd0);
        check({tag, "_lsu_rd"}, bus.lsu_rdata, 32'd0);
    endtask

    // One complete transaction: accept, `stall` cycles of memory backpressure, and a
    // response `delay` WAIT cycles later (delay >= TIMEOUT means memory never answers).
    task automatic run_txn(input logic iv, input logic [31:0] ia,
                           input logic lv, input logic [31:0] la, input logic lw,
                           input logic [31:0] wdat, input logic [7:0] wm,
                           input int unsigned stall, input int unsigned delay,
                           input logic [31:0] rd);
        logic        lsu_win;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic        e_wen;
        logic [7:0]  e_wmask;
        int unsigned last;
        logic        fire, resp, err;

        lsu_win = lv && (!iv || lsu_wins_tie());
        e_addr  = lsu_win ? la : ia;
        e_wen   = lsu_win && lw;
        e_wdata = lsu_win ? wdat : 32'd0;
        e_wmask = lsu_win ? wm : 8'd0;

        bus.ifu_req_valid  = iv;
        bus.ifu_addr       = ia;
        bus.lsu_req_valid  = lv;
        bus.lsu_addr       = la;
        bus.lsu_wen        = lw;
        bus.lsu_wdata      = wdat;
        bus.lsu_wmask      = wm;
        bus.mem_req_ready  = 1'($urandom_range(0, 1));
        bus.mem_resp_valid = 1'b0;
        #4;
        check("acc_ifu_ready", 32'(bus.ifu_req_ready), 32'(iv && !lsu_win));
        check("acc_lsu_ready", 32'(bus.lsu_req_ready), 32'(lsu_win));
        check("acc_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        check("acc_busy", 32'(bus.busy), 32'd0);
        tick();

        // Scramble request inputs: the latched copy must not follow them.
        bus.ifu_addr  = $urandom;
        bus.lsu_addr  = $urandom;
        bus.lsu_wen   = 1'($urandom_range(0, 1));
        bus.lsu_wdata = $urandom;
        bus.lsu_wmask = 8'($urandom);

        for (int unsigned s = 0; s <= stall; s++) begin
            bus.mem_req_ready  = (s == stall);
            bus.mem_resp_valid = (s == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.mem_rdata      = $urandom;
            #4;
            check("req_mem_valid", 32'(bus.mem_req_valid), 32'd1);
            check("req_addr", bus.mem_addr, e_addr);
            check("req_wen", 32'(bus.mem_wen), 32'(e_wen));
            check("req_wdata", bus.mem_wdata, e_wdata);
            check("req_wmask", 32'(bus.mem_wmask), 32'(e_wmask));
            check("req_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
            check("req_lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
            check("req_busy", 32'(bus.busy), 32'd1);
            check_quiet_resp("req");
            tick();
        end

        last = (delay < TIMEOUT) ? delay : TIMEOUT - 1;
        for (int unsigned w = 0; w <= last; w++) begin
            resp = (w == delay);
            fire = (w == last);
            err  = fire && !resp;
            e_rdata = err ? ERR_DATA : rd;
            bus.mem_req_ready  = 1'($urandom_range(0, 1));
            bus.mem_resp_valid = resp;
            bus.mem_rdata      = resp ? rd : $urandom;
            #4;
            check("wait_ifu_rv", 32'(bus.ifu_resp_valid), 32'(fire && !lsu_win));
            check("wait_lsu_rv", 32'(bus.lsu_resp_valid), 32'(fire && lsu_win));
            check("wait_ifu_err", 32'(bus.ifu_resp_err), 32'(err && !lsu_win));
            check("wait_lsu_err", 32'(bus.lsu_resp_err), 32'(err && lsu_win));
            check("wait_ifu_rdata", bus.ifu_rdata, (fire && !lsu_win) ? e_rdata : 32'd0);
            check("wait_lsu_rdata", bus.lsu_rdata, (fire && lsu_win) ? e_rdata : 32'd0);
            check("wait_mem_valid", 32'(bus.mem_req_valid), 32'd0);
            check("wait_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
            check("wait_lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
            check("wait_busy", 32'(bus.busy), 32'd1);
            tick();
        end

        bus.mem_resp_valid = 1'b0;
        bus.ifu_req_valid  = 1'b0;
        bus.lsu_req_valid  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_lsu = lsu_win;
`endif
        check("done_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic idle_stray();
        bus.ifu_req_valid  = 1'b0;
        bus.lsu_req_valid  = 1'b0;
        bus.mem_req_ready  = 1'($urandom_range(0, 1));
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = $urandom;
        #4;
        check_quiet_resp("idle");
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
    endtask

    initial begin
        logic iv, lv;
        int unsigned dly;

        rst = 1'b1;
        bus.ifu_req_valid  = 1'b1;
        bus.ifu_addr       = 32'h1111_1111;
        bus.lsu_req_valid  = 1'b1;
        bus.lsu_addr       = 32'h2222_2222;
        bus.lsu_wen        = 1'b1;
        bus.lsu_wdata      = 32'h3333_3333;
        bus.lsu_wmask      = 8'hFF;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        #2;
        check("rst_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
        check("rst_lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check_quiet_resp("rst");
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        tick();
        rst = 1'b0;

        // IFU-only fetch, minimum latency
        run_txn(1'b1, 32'h8000_0000, 1'b0, 32'd0, 1'b0, 32'd0, 8'd0, 0, 0, 32'h0000_0413);
        // LSU store under 4 cycles of backpressure
        run_txn(1'b0, 32'd0, 1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 8'h0F, 4, 1, 32'h0);
        // Two back-to-back ties
        run_txn(1'b1, 32'hA000_0000, 1'b1, 32'hB000_0000, 1'b0, 32'h0, 8'h0, 1, 0, 32'hCAFE_0001);
        run_txn(1'b1, 32'hA000_0004, 1'b1, 32'hB000_0004, 1'b1, 32'h55AA_55AA, 8'hF0, 0, 2, 32'hCAFE_0002);
        // Watchdog on an LSU load, then the boundary where the response lands on the last cycle
        run_txn(1'b0, 32'd0, 1'b1, 32'h9000_0000, 1'b0, 32'd0, 8'd0, 0, 1000, 32'h0);
        run_txn(1'b1, 32'h8000_0010, 1'b0, 32'd0, 1'b0, 32'd0, 8'd0, 0, TIMEOUT - 1, 32'h1357_9BDF);
        run_txn(1'b1, 32'h8000_0014, 1'b0, 32'd0, 1'b0, 32'd0, 8'd0, 0, 1000, 32'h0);
        // Stray response while idle
        idle_stray();

        // Reset asserted between edges while in WAIT
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h0000_1000;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.ifu_req_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b0;
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        bus.ifu_req_valid = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_mem_addr", bus.mem_addr, 32'd0);
        check("arst_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
        check("arst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        check_quiet_resp("arst");
        bus.ifu_req_valid = 1'b0;
        tick();
        rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_lsu = 1'b0;
`endif
        idle_stray();
        run_txn(1'b1, 32'h8000_0020, 1'b0, 32'd0, 1'b0, 32'd0, 8'd0, 0, 0, 32'h0BAD_F00D);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            iv = 1'($urandom_range(0, 1));
            lv = 1'($urandom_range(0, 1));
            dly = ($urandom_range(0, 7) == 0) ? 500 : $urandom_range(0, 4);
            if (!iv && !lv)
                idle_stray();
            else
                run_txn(iv, $urandom, lv, $urandom, 1'($urandom_range(0, 1)), $urandom,
                        8'($urandom), $urandom_range(0, 3), dly, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
